// File: rtl/uart_tx_engine_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_engine_pkg : shared state encoding and defaults for the UART TX path
// Revision: 1.0
// ============================================================================
package uart_tx_engine_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_CLK_DIV_DEFAULT = 868;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_engine_fifo.sv
`default_nettype none
// ============================================================================
// uart_fifo : synchronous FIFO with occupancy count, shared by the UART paths
// Revision: 1.0
// ============================================================================
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        din_i,
  output logic [WIDTH-1:0]        dout_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             push_ok,  pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// uart_tx_engine : buffered 8N1 UART transmitter (FIFO + baud counter + FSM).
// Define UART_TX_PARITY_EN to append an even parity bit to every frame.
// Revision: 1.0
// ============================================================================
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [UART_DATA_BITS-1:0]     tx_byte_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int                CNT_W     = $clog2(CLK_DIV);
  localparam int                IDX_W     = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  BIT_LAST  = IDX_W'(UART_DATA_BITS - 1);

  tx_state_e                  state_q,   state_d;
  logic [CNT_W-1:0]           baud_q,    baud_d;
  logic [IDX_W-1:0]           bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]  sh_q,      sh_d;
  logic                       tx_q,      tx_d;
`ifdef UART_TX_PARITY_EN
  logic                       parity_q,  parity_d;
`endif

  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [UART_DATA_BITS-1:0]  fifo_head;
  logic                       bit_end;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (valid_i),
    .pop_i   (fifo_pop),
    .din_i   (tx_byte_i),
    .dout_o  (fifo_head),
    .count_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ready_o = !fifo_full;
  assign busy_o  = (state_q != IDLE) || !fifo_empty;
  assign bit_end = (baud_q == BAUD_LAST);
  assign tx_o    = tx_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = '0;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    fifo_pop  = 1'b0;
    tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            sh_d      = sh_q >> 1;
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next frame so queued bytes leave back to back.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_pop) begin
      sh_d      = fifo_head;
      bit_idx_d = '0;
      baud_d    = '0;
`ifdef UART_TX_PARITY_EN
      parity_d  = even_parity(fifo_head);
`endif
    end

    // Line level follows the upcoming state so tx_o can stay a plain register.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// tb_uart_tx_engine : directed, table-driven checks of uart_tx_engine
// with CLK_DIV=4 and FIFO_DEPTH=4.
module tb_uart_tx_engine;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = 11;
`else
  localparam int NB    = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] tx_byte_i;
  logic       tx_o;
  logic       busy_o;
  logic [2:0] level_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int e1    = 0;
  bit log_en = 1'b0;

  logic tx_log[$];
  logic busy_log[$];
  logic exp_q[$];

  // line: start (bit 0), data LSB first, stop (bit 9); par: expected even parity.
  typedef struct packed {
    logic [7:0] data;
    logic [9:0] line;
    logic       par;
  } vec_t;

  vec_t single_tbl[4];
  vec_t burst_tbl[6];

  uart_tx_engine #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .tx_byte_i (tx_byte_i),
    .tx_o      (tx_o),
    .busy_o    (busy_o),
    .level_o   (level_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (log_en) begin
      tx_log.push_back(tx_o);
      busy_log.push_back(busy_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add_frame(input vec_t v);
    for (int i = 0; i < 9; i++) exp_q.push_back(v.line[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(v.par);
`endif
    exp_q.push_back(v.line[9]);
  endtask

  task automatic check_log(input string tag);
    int busy_low;
    busy_low = 0;
    chk({tag, " log_len"}, tx_log.size(), exp_q.size() * DIV);
    for (int k = 0; k < exp_q.size() && (k * DIV + DIV - 1) < tx_log.size(); k++) begin
      logic [DIV-1:0] got;
      for (int j = 0; j < DIV; j++) got[j] = tx_log[k * DIV + j];
      chk($sformatf("%s bit%0d", tag, k), got, {DIV{exp_q[k]}});
    end
    foreach (busy_log[i]) if (busy_log[i] !== 1'b1) busy_low++;
    chk({tag, " busy_in_frame_low"}, busy_low, 0);
    tx_log.delete();
    busy_log.delete();
    exp_q.delete();
  endtask

  initial begin
    single_tbl[0] = '{data: 8'h55, line: 10'b1_01010101_0, par: 1'b0};
    single_tbl[1] = '{data: 8'h07, line: 10'b1_00000111_0, par: 1'b1};
    single_tbl[2] = '{data: 8'h03, line: 10'b1_00000011_0, par: 1'b0};
    single_tbl[3] = '{data: 8'h81, line: 10'b1_10000001_0, par: 1'b0};

    burst_tbl[0]  = '{data: 8'hA5, line: 10'b1_10100101_0, par: 1'b0};
    burst_tbl[1]  = '{data: 8'h3C, line: 10'b1_00111100_0, par: 1'b0};
    burst_tbl[2]  = '{data: 8'hFF, line: 10'b1_11111111_0, par: 1'b0};
    burst_tbl[3]  = '{data: 8'h00, line: 10'b1_00000000_0, par: 1'b0};
    burst_tbl[4]  = '{data: 8'h66, line: 10'b1_01100110_0, par: 1'b0};
    burst_tbl[5]  = '{data: 8'h99, line: 10'b1_10011001_0, par: 1'b0};

    rst_n     = 1'b0;
    valid_i   = 1'b0;
    tx_byte_i = 8'h00;
    repeat (3) tick();
    chk("reset tx_o", tx_o, 1);
    chk("reset ready_o", ready_o, 1);
    chk("reset busy_o", busy_o, 0);
    chk("reset level_o", level_o, 0);
    rst_n = 1'b1;
    tick();
    chk("idle tx_o", tx_o, 1);
    chk("idle busy_o", busy_o, 0);

    // Single frames from an idle, empty engine.
    for (int t = 0; t < 4; t++) begin
      string nm;
      nm = $sformatf("single%0h", single_tbl[t].data);
      valid_i   = 1'b1;
      tx_byte_i = single_tbl[t].data;
      tick();
      valid_i   = 1'b0;
      chk({nm, " level_after_push"}, level_o, 1);
      chk({nm, " busy_after_push"}, busy_o, 1);
      chk({nm, " tx_still_idle"}, tx_o, 1);
      tick();
      log_en = 1'b1;
      chk({nm, " level_after_pop"}, level_o, 0);
      add_frame(single_tbl[t]);
      repeat (FRAME) tick();
      log_en = 1'b0;
      chk({nm, " busy_after_frame"}, busy_o, 0);
      chk({nm, " tx_after_frame"}, tx_o, 1);
      check_log(nm);
      repeat (3) tick();
    end

    // Burst: fill the FIFO, try a push while full, retry once space opens.
    valid_i   = 1'b1;
    tx_byte_i = burst_tbl[0].data;
    tick();
    chk("burst level1", level_o, 1);
    tx_byte_i = burst_tbl[1].data;
    tick();
    log_en = 1'b1;
    e1 = cyc;
    chk("burst level2", level_o, 1);
    tx_byte_i = burst_tbl[2].data;
    tick();
    chk("burst level3", level_o, 2);
    tx_byte_i = burst_tbl[3].data;
    tick();
    chk("burst level4", level_o, 3);
    chk("burst ready_not_full", ready_o, 1);
    tx_byte_i = burst_tbl[4].data;
    tick();
    chk("burst level_full", level_o, 4);
    chk("burst ready_full", ready_o, 0);
    tx_byte_i = 8'h99;
    repeat (3) tick();
    valid_i = 1'b0;
    chk("drop level_held", level_o, 4);
    chk("drop ready_low", ready_o, 0);
    for (int w = 0; w < 200 && !ready_o; w++) tick();
    chk("ready_rise_cycle", cyc - e1, FRAME);
    chk("ready_rise_level", level_o, 3);
    valid_i   = 1'b1;
    tx_byte_i = burst_tbl[5].data;
    tick();
    valid_i   = 1'b0;
    chk("retry level", level_o, 4);
    while (cyc - e1 < 6 * FRAME) tick();
    log_en = 1'b0;
    chk("burst busy_after", busy_o, 0);
    chk("burst level_after", level_o, 0);
    for (int f = 0; f < 6; f++) add_frame(burst_tbl[f]);
    check_log("burst");
    repeat (3) tick();

    // Reset during data bit 3 of 0xF0 with two bytes still queued.
    valid_i   = 1'b1;
    tx_byte_i = 8'hF0;
    tick();
    tx_byte_i = 8'h12;
    tick();
    e1 = cyc;
    tx_byte_i = 8'h34;
    tick();
    valid_i = 1'b0;
    chk("rst_test level_queued", level_o, 2);
    while (cyc - e1 < 4 * DIV + 1) tick();
    chk("rst_test tx_bit3", tx_o, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async tx_o", tx_o, 1);
    chk("rst_async level_o", level_o, 0);
    chk("rst_async busy_o", busy_o, 0);
    chk("rst_async ready_o", ready_o, 1);
    tick();
    tick();
    rst_n = 1'b1;
    begin
      int tx_low, busy_hi, lvl_nz;
      tx_low = 0; busy_hi = 0; lvl_nz = 0;
      for (int c = 0; c < 3 * FRAME; c++) begin
        tick();
        if (tx_o !== 1'b1) tx_low++;
        if (busy_o !== 1'b0) busy_hi++;
        if (level_o !== 3'd0) lvl_nz++;
      end
      chk("post_rst tx_low_cycles", tx_low, 0);
      chk("post_rst busy_cycles", busy_hi, 0);
      chk("post_rst level_nonzero_cycles", lvl_nz, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
